// File: rtl/cv32e40p_sleep_ctrl_if.sv
// rtl/cv32e40p_sleep_ctrl_if.sv - core-side signal bundle for the sleep/clock-gate controller
interface cv32e40p_sleep_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             fetch_enable_i;
  logic             sleep_req_i;
  logic             core_busy_i;
  logic             lsu_busy_i;
  logic             wake_irq_i;
  logic             debug_req_i;
  logic             sleep_cnt_clr_i;
  logic             clock_en_o;
  logic             core_sleep_o;
  logic             wake_ack_o;
  logic [CNT_W-1:0] sleep_cycles_o;

  // Core / environment side: drives requests, observes gating status.
  modport master (
    output fetch_enable_i, sleep_req_i, core_busy_i, lsu_busy_i,
           wake_irq_i, debug_req_i, sleep_cnt_clr_i,
    input  clock_en_o, core_sleep_o, wake_ack_o, sleep_cycles_o
  );

  // Controller side.
  modport slave (
    input  fetch_enable_i, sleep_req_i, core_busy_i, lsu_busy_i,
           wake_irq_i, debug_req_i, sleep_cnt_clr_i,
    output clock_en_o, core_sleep_o, wake_ack_o, sleep_cycles_o
  );
endinterface

// File: rtl/cv32e40p_sleep_ctrl.sv
// rtl/cv32e40p_sleep_ctrl.sv - WFI sleep sequencer producing the core clock-gate enable
module cv32e40p_sleep_ctrl #(
  parameter int IDLE_DELAY  = 4,
  parameter int WAKE_SETTLE = 2,
  parameter int CNT_W       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  cv32e40p_sleep_ctrl_if.slave  bus
);

  // One shared counter serves both the drain idle window and the wake settle window.
  localparam int CMAX = (IDLE_DELAY > WAKE_SETTLE) ? IDLE_DELAY : WAKE_SETTLE;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    SLEEP = 3'd3,
    WAKE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] sleep_cycles_q, sleep_cycles_d;
  logic             clock_en_q, clock_en_d;
  logic             core_sleep_q, core_sleep_d;
  logic             wake_ack_q, wake_ack_d;
  logic             wake_ev;
  logic             idle;

  assign wake_ev = bus.wake_irq_i | bus.debug_req_i;
  assign idle    = ~(bus.core_busy_i | bus.lsu_busy_i);

  // Next-state, counters and output decode; outputs derive from the next state so they register cleanly.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sleep_cycles_d = sleep_cycles_q;
    wake_ack_d     = 1'b0;

    case (state_q)
      BOOT: begin
        if (bus.fetch_enable_i) state_d = RUN;
      end
      RUN: begin
        // A pending wake source vetoes the sleep request outright.
        if (bus.sleep_req_i && !wake_ev) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        // Aborting beats drain progress, so a late wake never sees a gated clock.
        if (wake_ev || !bus.sleep_req_i) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (!idle) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(IDLE_DELAY - 1)) begin
          state_d = SLEEP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SLEEP: begin
        if (sleep_cycles_q != {CNT_W{1'b1}}) sleep_cycles_d = sleep_cycles_q + CNT_W'(1);
        if (wake_ev) begin
          state_d = WAKE;
          cnt_d   = '0;
        end
      end
      WAKE: begin
        // Settle runs to completion regardless of the wake source staying asserted.
        if (cnt_q == CW'(WAKE_SETTLE - 1)) begin
          state_d    = RUN;
          cnt_d      = '0;
          wake_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = BOOT;
        cnt_d   = '0;
      end
    endcase

    if (bus.sleep_cnt_clr_i) sleep_cycles_d = '0;

    clock_en_d   = (state_d == RUN) || (state_d == DRAIN) || (state_d == WAKE);
    core_sleep_d = (state_d == SLEEP) || (state_d == WAKE);
  end

  // State and registered outputs; async reset drops the clock enable at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= BOOT;
      cnt_q          <= '0;
      sleep_cycles_q <= '0;
      clock_en_q     <= 1'b0;
      core_sleep_q   <= 1'b0;
      wake_ack_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sleep_cycles_q <= sleep_cycles_d;
      clock_en_q     <= clock_en_d;
      core_sleep_q   <= core_sleep_d;
      wake_ack_q     <= wake_ack_d;
    end
  end

  assign bus.clock_en_o     = clock_en_q;
  assign bus.core_sleep_o   = core_sleep_q;
  assign bus.wake_ack_o     = wake_ack_q;
  assign bus.sleep_cycles_o = sleep_cycles_q;

endmodule

// File: tb/tb_cv32e40p_sleep_ctrl.sv
// tb/tb_cv32e40p_sleep_ctrl.sv - scoreboard bench for the sleep/clock-gate controller
module tb_cv32e40p_sleep_ctrl;

  localparam int IDLE_DELAY  = 4;
  localparam int WAKE_SETTLE = 2;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  typedef struct {
    logic             en;
    logic             slp;
    logic             ack;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  cv32e40p_sleep_ctrl_if #(.CNT_W(CNT_W)) bus ();

  cv32e40p_sleep_ctrl #(
    .IDLE_DELAY (IDLE_DELAY),
    .WAKE_SETTLE(WAKE_SETTLE),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain booleans describing what the core is doing.
  bit started, draining, asleep, waking, m_ack;
  int idle_run, settled, m_cnt;

  task automatic model_reset();
    started = 0; draining = 0; asleep = 0; waking = 0; m_ack = 0;
    idle_run = 0; settled = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit wake, busy, was_asleep;
    if (!rst_n) begin
      model_reset();
      return;
    end
    wake       = bus.wake_irq_i || bus.debug_req_i;
    busy       = bus.core_busy_i || bus.lsu_busy_i;
    was_asleep = asleep;
    m_ack      = 0;
    if (!started) begin
      if (bus.fetch_enable_i) started = 1;
    end else if (asleep) begin
      if (wake) begin asleep = 0; waking = 1; settled = 0; end
    end else if (waking) begin
      settled++;
      if (settled == WAKE_SETTLE) begin waking = 0; m_ack = 1; end
    end else if (draining) begin
      if (wake || !bus.sleep_req_i) draining = 0;
      else if (busy) idle_run = 0;
      else begin
        idle_run++;
        if (idle_run == IDLE_DELAY) begin draining = 0; asleep = 1; end
      end
    end else if (bus.sleep_req_i && !wake) begin
      draining = 1; idle_run = 0;
    end
    if (bus.sleep_cnt_clr_i) m_cnt = 0;
    else if (was_asleep && m_cnt < CNT_MAX) m_cnt++;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.en  = started && !asleep;
    e.slp = asleep || waking;
    e.ack = m_ack;
    e.cnt = CNT_W'(m_cnt);
    return e;
  endfunction

  task automatic check_outs(input string name, input exp_t e);
    checks++;
    if (bus.clock_en_o !== e.en || bus.core_sleep_o !== e.slp ||
        bus.wake_ack_o !== e.ack || bus.sleep_cycles_o !== e.cnt) begin
      errors++;
      $display("FAIL %s t=%0t got en=%0b slp=%0b ack=%0b cnt=%0d expected en=%0b slp=%0b ack=%0b cnt=%0d",
               name, $time, bus.clock_en_o, bus.core_sleep_o, bus.wake_ack_o, bus.sleep_cycles_o,
               e.en, e.slp, e.ack, e.cnt);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got %0b expected %0b", name, $time, got, want);
    end
  endtask

  task automatic check_cnt(input string name, input int want);
    checks++;
    if (int'(bus.sleep_cycles_o) != want) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, bus.sleep_cycles_o, want);
    end
  endtask

  // Monitor: every negedge the DUT presents a fresh output word; compare with the oldest prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) check_outs("scoreboard", exp_q.pop_front());
  end

  // One clock of stimulus; called at negedge+1, returns at the next negedge+1.
  task automatic cyc(input bit fe, input bit sr, input bit cb, input bit lb,
                     input bit wi, input bit dr, input bit clr);
    bus.fetch_enable_i  = fe;
    bus.sleep_req_i     = sr;
    bus.core_busy_i     = cb;
    bus.lsu_busy_i      = lb;
    bus.wake_irq_i      = wi;
    bus.debug_req_i     = dr;
    bus.sleep_cnt_clr_i = clr;
    @(posedge clk);
    model_step();
    exp_q.push_back(model_out());
    @(negedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n, input bit sr);
    repeat (n) cyc(0, sr, 0, 0, 0, 0, 0);
  endtask

  task automatic async_reset(input int hold);
    exp_t z;
    z.en = 0; z.slp = 0; z.ack = 0; z.cnt = '0;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset_immediate", z);
    model_reset();
    repeat (hold) cyc(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    model_reset();
    bus.fetch_enable_i = 0; bus.sleep_req_i = 0; bus.core_busy_i = 0; bus.lsu_busy_i = 0;
    bus.wake_irq_i = 0; bus.debug_req_i = 0; bus.sleep_cnt_clr_i = 0;
    @(negedge clk);
    #1;
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
    check_bit("reset_clock_en", bus.clock_en_o, 1'b0);
    rst_n = 1'b1;

    // Boot: fetch enable at cycle 3, dropped afterwards (sticky).
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    check_bit("boot_gated_before_fetch", bus.clock_en_o, 1'b0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check_bit("boot_enabled_after_fetch", bus.clock_en_o, 1'b1);
    idle_cycles(3, 0);

    // Drain with no busy: gated exactly IDLE_DELAY cycles after DRAIN entry.
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle_cycles(IDLE_DELAY - 1, 1);
    check_bit("drain_not_yet_gated", bus.clock_en_o, 1'b1);
    idle_cycles(1, 1);
    check_bit("drain_gated", bus.clock_en_o, 1'b0);
    cyc(0, 1, 0, 0, 1, 0, 0);
    check_bit("wake_latency", bus.clock_en_o, 1'b1);
    idle_cycles(WAKE_SETTLE, 0);
    check_bit("wake_ack_pulse", bus.wake_ack_o, 1'b1);
    idle_cycles(1, 0);
    check_bit("wake_ack_single", bus.wake_ack_o, 1'b0);

    // LSU busy on the third idle cycle restarts the window: gating slips by 3.
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle_cycles(2, 1);
    cyc(0, 1, 0, 1, 0, 0, 0);
    idle_cycles(IDLE_DELAY - 1, 1);
    check_bit("busy_restart_not_gated", bus.clock_en_o, 1'b1);
    idle_cycles(1, 1);
    check_bit("busy_restart_gated", bus.clock_en_o, 1'b0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle_cycles(WAKE_SETTLE + 1, 0);

    // Sleep exactly 10 cycles from a cleared counter.
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle_cycles(IDLE_DELAY, 1);
    repeat (9) cyc(0, 1, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 0);
    check_cnt("sleep_ten_cycles", 10);
    idle_cycles(WAKE_SETTLE + 1, 0);

    // Simultaneous sleep+debug stays RUN; wake during DRAIN aborts.
    cyc(0, 1, 0, 0, 0, 1, 0);
    check_bit("sleep_debug_same_cycle", bus.clock_en_o, 1'b1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 0);
    idle_cycles(IDLE_DELAY + 2, 0);
    check_bit("drain_abort_no_gate", bus.clock_en_o, 1'b1);

    // Saturation and clear during SLEEP.
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle_cycles(IDLE_DELAY, 1);
    idle_cycles(20, 1);
    check_cnt("sleep_saturate", CNT_MAX);
    cyc(0, 1, 0, 0, 0, 0, 1);
    check_cnt("sleep_clear", 0);
    idle_cycles(1, 1);
    check_cnt("sleep_after_clear", 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    idle_cycles(WAKE_SETTLE + 1, 0);

    // Reset while in SLEEP, then while in WAKE.
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle_cycles(IDLE_DELAY + 3, 1);
    async_reset(2);
    idle_cycles(3, 1);
    check_bit("boot_needs_fetch", bus.clock_en_o, 1'b0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle_cycles(IDLE_DELAY + 2, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    async_reset(1);
    idle_cycles(2, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset($urandom_range(0, 2));
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 39) == 0);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
